mfp_mac_seq_ctrl: RTL and testbench

//  Sequencer for one external MFP_MAC_Seq instance: accepts a stream of operand pairs (valid/ready),

---
 rtl/mfp_mac_seq_ctrl_pkg.sv | 29 ++
 rtl/mfp_mac_tap_cnt.sv | 44 ++++
 rtl/mfp_mac_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_mfp_mac_seq_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_mac_seq_ctrl_pkg.sv
// ============================================================================
// Module   : mfp_mac_seq_ctrl_pkg
// Purpose  : Shared state encodings and a clog2 helper for the MAC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mfp_mac_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC   = 3'd1,
        S_FLUSH = 3'd2,
        S_CAP   = 3'd3,
        S_OUT   = 3'd4
    } mac_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mfp_mac_tap_cnt.sv
// ============================================================================
// Module   : mfp_mac_tap_cnt
// Purpose  : Counts accepted operand pairs and flags the pair that ends a vector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfp_mac_tap_cnt #(
    parameter int DOT_LEN = 9,
    parameter int CNTW    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    input  logic            last_i,
    output logic [CNTW-1:0] count,
    output logic            eov
);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic [CNTW-1:0] cnt_nxt;

    // clr accompanies the first pair of a vector, so the post-increment count is 1.
    always_comb begin
        cnt_nxt = clr ? CNTW'(1) : cnt_q + CNTW'(1);
        cnt_d   = inc ? cnt_nxt : cnt_q;
        eov     = inc && (last_i || (cnt_nxt == CNTW'(DOT_LEN)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

`default_nettype wire

// File: rtl/mfp_mac_seq_ctrl.sv
// ============================================================================
// Module   : mfp_mac_seq_ctrl
// Purpose  : Sequences operand pairs into an external MFP_MAC_Seq and holds each
//            finished dot product. Option macro: MFP_MAC_CTRL_LAST_EN (in_last).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfp_mac_seq_ctrl
    import mfp_mac_seq_ctrl_pkg::*;
#(
    parameter int IN1W    = 8,
    parameter int IN2W    = IN1W,
    parameter int ACCW    = IN1W + IN2W - 1,
    parameter int DOT_LEN = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN1W-1:0] in_a,
    input  logic [IN2W-1:0] in_b,
`ifdef MFP_MAC_CTRL_LAST_EN
    input  logic            in_last,
`endif
    output logic [IN1W-1:0] mac_in1,
    output logic [IN2W-1:0] mac_in2,
    output logic            mac_aclr,
    input  logic [ACCW-1:0] mac_acc,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [ACCW-1:0] res_data,
    output logic            busy
);

    localparam int CNTW = clog2(DOT_LEN + 1);

    mac_state_t      state_q, state_d;
    logic [IN1W-1:0] mac_in1_q, mac_in1_d;
    logic [IN2W-1:0] mac_in2_q, mac_in2_d;
    logic            mac_aclr_q, mac_aclr_d;
    logic            res_valid_q, res_valid_d;
    logic [ACCW-1:0] res_data_q, res_data_d;

    logic            hs;
    logic            eov;
    logic            last_in;
    logic [CNTW-1:0] unused_tap_count;

`ifdef MFP_MAC_CTRL_LAST_EN
    assign last_in = in_last;
`else
    assign last_in = 1'b0;
`endif

    assign in_ready = (state_q == S_IDLE) || (state_q == S_ACC);
    assign hs       = in_valid && in_ready;

    mfp_mac_tap_cnt #(
        .DOT_LEN (DOT_LEN),
        .CNTW    (CNTW)
    ) u_tap_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q == S_IDLE),
        .inc    (hs),
        .last_i (last_in),
        .count  (unused_tap_count),
        .eov    (eov)
    );

    always_comb begin
        state_d     = state_q;
        mac_in1_d   = mac_in1_q;
        // Bubbles feed a zero product so the MAC accumulator is left untouched.
        mac_in2_d   = '0;
        mac_aclr_d  = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        if (hs) begin
            mac_in1_d  = in_a;
            mac_in2_d  = in_b;
            mac_aclr_d = (state_q == S_IDLE);
        end

        case (state_q)
            S_IDLE, S_ACC: begin
                if (hs) begin
                    state_d = eov ? S_FLUSH : S_ACC;
                end
            end
            S_FLUSH: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                res_data_d  = mac_acc;
                res_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mac_in1_q   <= '0;
            mac_in2_q   <= '0;
            mac_aclr_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mac_in1_q   <= mac_in1_d;
            mac_in2_q   <= mac_in2_d;
            mac_aclr_q  <= mac_aclr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign mac_in1   = mac_in1_q;
    assign mac_in2   = mac_in2_q;
    assign mac_aclr  = mac_aclr_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mfp_mac_seq_ctrl.sv
// ============================================================================
// Module   : tb_mfp_mac_seq_ctrl
// Purpose  : Directed bench for mfp_mac_seq_ctrl with a behavioural MAC model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mfp_mac_seq_ctrl;

    localparam int IN1W    = 8;
    localparam int IN2W    = 8;
    localparam int ACCW    = 15;
    localparam int DOT_LEN = 4;

    typedef struct {
        logic [3:0][7:0]   a;
        logic [3:0][7:0]   b;
        bit                toggle;
        int                hold;
        logic [ACCW-1:0]   res;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [IN1W-1:0] in_a;
    logic [IN2W-1:0] in_b;
    logic            in_last;
    logic [IN1W-1:0] mac_in1;
    logic [IN2W-1:0] mac_in2;
    logic            mac_aclr;
    logic [ACCW-1:0] mac_acc;
    logic            res_valid;
    logic            res_ready;
    logic [ACCW-1:0] res_data;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    // MAC model: never reset, starts from a stale value.
    logic [ACCW-1:0]   acc_q = 15'h2a5a;
    logic signed [15:0] prod;
    assign prod    = $signed(mac_in1) * $signed(mac_in2);
    assign mac_acc = acc_q;
    always @(posedge clk) begin
        acc_q <= mac_aclr ? prod[ACCW-1:0] : acc_q + prod[ACCW-1:0];
    end

    mfp_mac_seq_ctrl #(
        .IN1W    (IN1W),
        .IN2W    (IN2W),
        .ACCW    (ACCW),
        .DOT_LEN (DOT_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef MFP_MAC_CTRL_LAST_EN
        .in_last   (in_last),
`endif
        .mac_in1   (mac_in1),
        .mac_in2   (mac_in2),
        .mac_aclr  (mac_aclr),
        .mac_acc   (mac_acc),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b,
                             input bit first, input bit last);
        bit hs;
        bit done;
        int t;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        done     = 1'b0;
        t        = 0;
        while (!done) begin
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                done = 1'b1;
            end else begin
                t++;
                if (t > 50) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL in_ready timeout");
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("mac_in1", 32'(mac_in1), 32'(a));
        chk("mac_in2", 32'(mac_in2), 32'(b));
        chk("mac_aclr", 32'(mac_aclr), 32'(first));
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bubble_in2", 32'(mac_in2), 32'd0);
        chk("bubble_aclr", 32'(mac_aclr), 32'd0);
    endtask

    // Called 1 ns after the last-pair handshake edge.
    task automatic finish_vec(input logic [ACCW-1:0] expv, input int hold);
        chk("flush_valid", 32'(res_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("cap_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_data", 32'(res_data), 32'(expv));
        chk("out_ready", 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", 32'(res_data), 32'(expv));
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("taken_valid", 32'(res_valid), 32'd0);
        chk("taken_busy", 32'(busy), 32'd0);
        chk("taken_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        for (int k = 0; k < DOT_LEN; k++) begin
            send_pair(v.a[k], v.b[k], (k == 0), 1'b0);
            if (v.toggle && (k < DOT_LEN - 1)) bubble();
        end
        finish_vec(v.res, v.hold);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_data"}, 32'(res_data), 32'd0);
        chk({tag, "_mac_in1"}, 32'(mac_in1), 32'd0);
        chk({tag, "_mac_in2"}, 32'(mac_in2), 32'd0);
        chk({tag, "_mac_aclr"}, 32'(mac_aclr), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5},
                    toggle: 1'b0, hold: 0, res: 15'd70};
        vecs[1] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5},
                    toggle: 1'b1, hold: 0, res: 15'd70};
        vecs[2] = '{a: {8'd4, 8'd3, 8'hFE, 8'hFF}, b: {8'd10, 8'd10, 8'd10, 8'd10},
                    toggle: 1'b0, hold: 10, res: 15'd40};
        vecs[3] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5},
                    toggle: 1'b0, hold: 0, res: 15'd70};
        vecs[4] = '{a: {8'd1, 8'd1, 8'd1, 8'd1}, b: {8'hFD, 8'hFD, 8'hFD, 8'hFD},
                    toggle: 1'b0, hold: 0, res: 15'h7FF4};
        vecs[5] = '{a: {8'd127, 8'd127, 8'd127, 8'd127}, b: {8'd127, 8'd127, 8'd127, 8'd127},
                    toggle: 1'b1, hold: 2, res: 15'h7C04};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of a vector discards the partial sum.
        send_pair(8'd9, 8'd9, 1'b1, 1'b0);
        send_pair(8'd9, 8'd9, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("midrst_hold");
        rst_n = 1'b1;
        run_vec('{a: {8'd1, 8'd1, 8'd1, 8'd1}, b: {8'd2, 8'd2, 8'd2, 8'd2},
                  toggle: 1'b0, hold: 0, res: 15'd8});

`ifdef MFP_MAC_CTRL_LAST_EN
        send_pair(8'd2, 8'd4, 1'b1, 1'b0);
        send_pair(8'd3, 8'd5, 1'b0, 1'b1);
        finish_vec(15'd23, 0);
        run_vec(vecs[0]);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
